calc_core_param: RTL and testbench

- Parametrised, keypad-driven integer calculator core; successor to the fixed 8-bit add/subtract control unit and AU pair.
- Consumes key strobes from the keypad input unit and performs decimal operand entry, operator latching and chained add/subtract.
- Flags are registered; the value to display is driven to the 7-segment output unit.
- Sits between the keypad input unit and the output unit in the calculator top level.

---
 rtl/calc_core_param.sv | 235 +++++++++++++++++++++++
 tb/tb_calc_core_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_core_param.sv
// Keypad-driven calculator core: decimal operand entry, operator latching, chained add/sub.
// Optional macro CALC_MUL_EN turns key 0xE into a multiply operator.
module calc_core_param #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clrEn,
   input  logic             trig,
   input  logic [3:0]       value,
   output logic [WIDTH-1:0] DISP,
   output logic             show_res,
   output logic             ovf,
   output logic             borrow,
   output logic             zero,
   output logic [2:0]       state
);

   localparam int unsigned EW = WIDTH + 4;
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam logic [EW-1:0] MAX_V = {4'b0000, {WIDTH{1'b1}}};

   typedef enum logic [2:0] {
      S_A   = 3'd0,
      S_OP  = 3'd1,
      S_B   = 3'd2,
      S_RES = 3'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2
   } op_t;

   state_t           st, st_n;
   op_t              op, op_n, key_op;
   logic [WIDTH-1:0] a, a_n, b, b_n, r, r_n, disp_n;
   logic [CW-1:0]    cnt_a, cnt_a_n, cnt_b, cnt_b_n, cnt_cur, cnt_new;
   logic             ovf_n, borrow_n, zero_n, show_n;
   logic             clr_req, is_digit, is_op, is_eq, digit_ok;
   logic [WIDTH-1:0] acc, digit_val;
   logic [EW-1:0]    next_val;
   logic [WIDTH-1:0] alu_x, alu_res;
   logic [WIDTH:0]   sum;
   logic             alu_ovf, alu_bor, alu_zero;
`ifdef CALC_MUL_EN
   localparam int unsigned PW = 2 * WIDTH;
   logic [PW-1:0]    prod;
`endif

   // Key decode; a clear-entry request always beats the key strobe
   always_comb begin
      clr_req  = ~clrEn | (trig & (value == 4'hC));
      is_digit = (value < 4'hA);
      is_eq    = (value == 4'hD);
      is_op    = 1'b0;
      key_op   = OP_ADD;
      case (value)
         4'hA: is_op = 1'b1;
         4'hB: begin
            is_op  = 1'b1;
            key_op = OP_SUB;
         end
`ifdef CALC_MUL_EN
         4'hE: begin
            is_op  = 1'b1;
            key_op = OP_MUL;
         end
`endif
         default: ;
      endcase
   end

   // Decimal accumulation for whichever operand the current state is building
   always_comb begin
      acc       = (st == S_A) ? a : (st == S_B) ? b : '0;
      cnt_cur   = (st == S_A) ? cnt_a : (st == S_B) ? cnt_b : '0;
      next_val  = EW'(acc) * EW'(10) + EW'(value);
      digit_ok  = (next_val <= MAX_V) && (cnt_cur < CW'(DIGITS));
      cnt_new   = (next_val == '0) ? '0 : cnt_cur + CW'(1);
      digit_val = next_val[WIDTH-1:0];
   end

   // Arithmetic unit; left operand is R when repeating equals from the result state
   always_comb begin
      alu_x   = (st == S_RES) ? r : a;
      sum     = {1'b0, alu_x} + {1'b0, b};
      alu_res = sum[WIDTH-1:0];
      alu_ovf = 1'b0;
      alu_bor = 1'b0;
`ifdef CALC_MUL_EN
      prod    = PW'(alu_x) * PW'(b);
`endif
      case (op)
         OP_ADD: alu_ovf = sum[WIDTH];
         OP_SUB: begin
            alu_res = alu_x - b;
            alu_bor = (b > alu_x);
         end
`ifdef CALC_MUL_EN
         OP_MUL: begin
            alu_res = prod[WIDTH-1:0];
            alu_ovf = (prod[PW-1:WIDTH] != '0);
         end
`endif
         default: ;
      endcase
      alu_zero = (alu_res == '0);
   end

   // Next-state and datapath updates
   always_comb begin
      st_n     = st;
      op_n     = op;
      a_n      = a;
      b_n      = b;
      r_n      = r;
      cnt_a_n  = cnt_a;
      cnt_b_n  = cnt_b;
      ovf_n    = ovf;
      borrow_n = borrow;
      zero_n   = zero;
      if (clr_req) begin
         case (st)
            S_A: begin
               a_n     = '0;
               cnt_a_n = '0;
            end
            S_B: begin
               b_n     = '0;
               cnt_b_n = '0;
            end
            S_RES: begin
               st_n     = S_A;
               op_n     = OP_ADD;
               a_n      = '0;
               b_n      = '0;
               r_n      = '0;
               cnt_a_n  = '0;
               cnt_b_n  = '0;
               ovf_n    = 1'b0;
               borrow_n = 1'b0;
               zero_n   = 1'b0;
            end
            default: ;
         endcase
      end else if (trig) begin
         if (is_digit) begin
            if (digit_ok) begin
               case (st)
                  S_A: begin
                     a_n     = digit_val;
                     cnt_a_n = cnt_new;
                  end
                  S_OP, S_B: begin
                     st_n    = S_B;
                     b_n     = digit_val;
                     cnt_b_n = cnt_new;
                  end
                  S_RES: begin
                     st_n     = S_A;
                     a_n      = digit_val;
                     cnt_a_n  = cnt_new;
                     ovf_n    = 1'b0;
                     borrow_n = 1'b0;
                     zero_n   = 1'b0;
                  end
                  default: ;
               endcase
            end
         end else if (is_op) begin
            op_n = key_op;
            st_n = S_OP;
            case (st)
               S_B: begin
                  r_n      = alu_res;
                  a_n      = alu_res;
                  ovf_n    = alu_ovf;
                  borrow_n = alu_bor;
                  zero_n   = alu_zero;
               end
               S_RES: a_n = r;
               default: ;
            endcase
         end else if (is_eq && (st == S_B || st == S_RES)) begin
            st_n     = S_RES;
            r_n      = alu_res;
            ovf_n    = alu_ovf;
            borrow_n = alu_bor;
            zero_n   = alu_zero;
         end
      end
      case (st_n)
         S_B:     disp_n = b_n;
         S_RES:   disp_n = r_n;
         default: disp_n = a_n;
      endcase
      show_n = (st_n == S_RES);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         st       <= S_A;
         op       <= OP_ADD;
         a        <= '0;
         b        <= '0;
         r        <= '0;
         cnt_a    <= '0;
         cnt_b    <= '0;
         DISP     <= '0;
         show_res <= 1'b0;
         ovf      <= 1'b0;
         borrow   <= 1'b0;
         zero     <= 1'b0;
      end else begin
         st       <= st_n;
         op       <= op_n;
         a        <= a_n;
         b        <= b_n;
         r        <= r_n;
         cnt_a    <= cnt_a_n;
         cnt_b    <= cnt_b_n;
         DISP     <= disp_n;
         show_res <= show_n;
         ovf      <= ovf_n;
         borrow   <= borrow_n;
         zero     <= zero_n;
      end
   end

   assign state = st;

endmodule

// File: tb/tb_calc_core_param.sv
// Bench for calc_core_param: directed key table plus randomized keys against a reference model.
module tb_calc_core_param;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned DIGITS = 3;
`ifdef CALC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RESET, clrEn, trig;
   logic [3:0]       value;
   logic [WIDTH-1:0] DISP;
   logic             show_res, ovf, borrow, zero;
   logic [2:0]       state;

   int n_cmp = 0;
   int n_bad = 0;

   calc_core_param #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .CLK(CLK), .RESET(RESET), .clrEn(clrEn), .trig(trig), .value(value),
      .DISP(DISP), .show_res(show_res), .ovf(ovf), .borrow(borrow), .zero(zero),
      .state(state)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       clr_n;
      logic       trg;
      logic [3:0] key;
      logic [7:0] disp;
      logic [2:0] st;
      logic       ov;
      logic       bo;
      logic       zr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic c, input logic t, input logic [3:0] k,
                              input int d, input int s, input logic o, input logic bb,
                              input logic z);
      vec_t x;
      x.clr_n = c; x.trg = t; x.key = k; x.disp = 8'(d); x.st = 3'(s);
      x.ov = o; x.bo = bb; x.zr = z;
      return x;
   endfunction

   task automatic check(input string nm, input logic [7:0] d, input logic [2:0] s,
                        input logic o, input logic bb, input logic z);
      logic sr;
      sr = (s == 3'd3);
      n_cmp++;
      if (DISP !== d || show_res !== sr || ovf !== o || borrow !== bb || zero !== z ||
          state !== s) begin
         n_bad++;
         $display("FAIL %s: got disp=%0d show=%b ovf=%b bor=%b zero=%b st=%0d, want disp=%0d show=%b ovf=%b bor=%b zero=%b st=%0d",
                  nm, DISP, show_res, ovf, borrow, zero, state, d, sr, o, bb, z, s);
      end
   endtask

   task automatic drive(input logic c, input logic t, input logic [3:0] k);
      clrEn = c; trig = t; value = k;
      @(posedge CLK);
      #1;
      trig = 1'b0; clrEn = 1'b1;
   endtask

   // Reference model: spec-level calculator over plain integers
   localparam int MS_A = 0, MS_OP = 1, MS_B = 2, MS_RES = 3;
   int ma, mb, mr, mop, mst, na, nb;
   bit mov, mbo, mzr;

   task automatic m_reset();
      ma = 0; mb = 0; mr = 0; mop = 10; mst = MS_A; na = 0; nb = 0;
      mov = 0; mbo = 0; mzr = 0;
   endtask

   task automatic m_compute(input int x);
      int full;
      mov = 0; mbo = 0;
      if (mop == 10) begin full = x + mb; mov = (full > 255); end
      else if (mop == 11) begin full = x - mb + 256; mbo = (mb > x); end
      else begin full = x * mb; mov = (full > 255); end
      mr  = full % 256;
      mzr = (mr == 0);
   endtask

   task automatic m_step(input bit c_n, input bit t, input int k);
      int accv, cnt, nxt;
      bit isop;
      isop = (k == 10) || (k == 11) || (MUL_EN && k == 14);
      if (!c_n || (t && k == 12)) begin
         if (mst == MS_A) begin ma = 0; na = 0; end
         else if (mst == MS_B) begin mb = 0; nb = 0; end
         else if (mst == MS_RES) m_reset();
      end else if (t) begin
         if (k <= 9) begin
            accv = (mst == MS_A) ? ma : (mst == MS_B) ? mb : 0;
            cnt  = (mst == MS_A) ? na : (mst == MS_B) ? nb : 0;
            nxt  = accv * 10 + k;
            if (nxt <= 255 && cnt < int'(DIGITS)) begin
               cnt = (nxt == 0) ? 0 : cnt + 1;
               if (mst == MS_A) begin ma = nxt; na = cnt; end
               else if (mst == MS_RES) begin
                  ma = nxt; na = cnt; mst = MS_A; mov = 0; mbo = 0; mzr = 0;
               end else begin mb = nxt; nb = cnt; mst = MS_B; end
            end
         end else if (isop) begin
            if (mst == MS_B) begin m_compute(ma); ma = mr; end
            else if (mst == MS_RES) ma = mr;
            mop = k; mst = MS_OP;
         end else if (k == 13) begin
            if (mst == MS_B) begin m_compute(ma); mst = MS_RES; end
            else if (mst == MS_RES) m_compute(mr);
         end
      end
   endtask

   function automatic int m_disp();
      if (mst == MS_B) return mb;
      if (mst == MS_RES) return mr;
      return ma;
   endfunction

   initial begin
      int rr, kk;
      bit cc, tt;
      RESET = 1'b0; clrEn = 1'b1; trig = 1'b0; value = 4'h0;
      #12;
      check("reset", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      // 12+34
      tbl.push_back(v(1,1,4'h1,   1,0,0,0,0));
      tbl.push_back(v(1,1,4'h2,  12,0,0,0,0));
      tbl.push_back(v(1,1,4'hA,  12,1,0,0,0));
      tbl.push_back(v(1,1,4'h3,   3,2,0,0,0));
      tbl.push_back(v(1,1,4'h4,  34,2,0,0,0));
      tbl.push_back(v(1,1,4'hD,  46,3,0,0,0));
      // 200+100 wraps to 44 with carry
      tbl.push_back(v(1,1,4'h2,   2,0,0,0,0));
      tbl.push_back(v(1,1,4'h0,  20,0,0,0,0));
      tbl.push_back(v(1,1,4'h0, 200,0,0,0,0));
      tbl.push_back(v(1,1,4'hA, 200,1,0,0,0));
      tbl.push_back(v(1,1,4'h1,   1,2,0,0,0));
      tbl.push_back(v(1,1,4'h0,  10,2,0,0,0));
      tbl.push_back(v(1,1,4'h0, 100,2,0,0,0));
      tbl.push_back(v(1,1,4'hD,  44,3,1,0,0));
      // 5-7 borrows
      tbl.push_back(v(1,1,4'h5,   5,0,0,0,0));
      tbl.push_back(v(1,1,4'hB,   5,1,0,0,0));
      tbl.push_back(v(1,1,4'h7,   7,2,0,0,0));
      tbl.push_back(v(1,1,4'hD, 254,3,0,1,0));
      // range and digit-count limits
      tbl.push_back(v(1,1,4'h2,   2,0,0,0,0));
      tbl.push_back(v(1,1,4'h5,  25,0,0,0,0));
      tbl.push_back(v(1,1,4'h6,  25,0,0,0,0));
      tbl.push_back(v(1,1,4'hC,   0,0,0,0,0));
      tbl.push_back(v(1,1,4'h1,   1,0,0,0,0));
      tbl.push_back(v(1,1,4'h2,  12,0,0,0,0));
      tbl.push_back(v(1,1,4'h3, 123,0,0,0,0));
      tbl.push_back(v(1,1,4'h4, 123,0,0,0,0));
      tbl.push_back(v(0,0,4'h0,   0,0,0,0,0));
      tbl.push_back(v(1,1,4'hF,   0,0,0,0,0));
      tbl.push_back(v(1,1,4'hD,   0,0,0,0,0));
      // chaining 9+1-3, then repeated equals
      tbl.push_back(v(1,1,4'h9,   9,0,0,0,0));
      tbl.push_back(v(1,1,4'hA,   9,1,0,0,0));
      tbl.push_back(v(1,1,4'hD,   9,1,0,0,0));
      tbl.push_back(v(1,1,4'h1,   1,2,0,0,0));
      tbl.push_back(v(1,1,4'hB,  10,1,0,0,0));
      tbl.push_back(v(1,1,4'hB,  10,1,0,0,0));
      tbl.push_back(v(1,1,4'h3,   3,2,0,0,0));
      tbl.push_back(v(1,1,4'hD,   7,3,0,0,0));
      tbl.push_back(v(1,1,4'hD,   4,3,0,0,0));
      // clear entry of B
      tbl.push_back(v(1,1,4'h8,   8,0,0,0,0));
      tbl.push_back(v(1,1,4'hA,   8,1,0,0,0));
      tbl.push_back(v(1,1,4'h5,   5,2,0,0,0));
      tbl.push_back(v(0,0,4'h0,   0,2,0,0,0));
      tbl.push_back(v(1,1,4'h2,   2,2,0,0,0));
      tbl.push_back(v(1,1,4'hD,  10,3,0,0,0));
      // clrEn with a simultaneous digit: clear wins
      tbl.push_back(v(0,1,4'h7,   0,0,0,0,0));
      tbl.push_back(v(1,1,4'h4,   4,0,0,0,0));
      tbl.push_back(v(0,1,4'h7,   0,0,0,0,0));
      // zero result
      tbl.push_back(v(1,1,4'h5,   5,0,0,0,0));
      tbl.push_back(v(1,1,4'hB,   5,1,0,0,0));
      tbl.push_back(v(1,1,4'h5,   5,2,0,0,0));
      tbl.push_back(v(1,1,4'hD,   0,3,0,0,1));
      tbl.push_back(v(0,0,4'h0,   0,0,0,0,0));
      // leading zeros do not count
      tbl.push_back(v(1,1,4'h0,   0,0,0,0,0));
      tbl.push_back(v(1,1,4'h0,   0,0,0,0,0));
      tbl.push_back(v(1,1,4'h1,   1,0,0,0,0));
      tbl.push_back(v(1,1,4'h2,  12,0,0,0,0));
      tbl.push_back(v(1,1,4'h3, 123,0,0,0,0));
      tbl.push_back(v(1,1,4'h4, 123,0,0,0,0));
      // key 0xE
      tbl.push_back(v(1,1,4'hC,   0,0,0,0,0));
      tbl.push_back(v(1,1,4'h3,   3,0,0,0,0));
      tbl.push_back(v(1,1,4'hE,   3, MUL_EN ? 1 : 0,0,0,0));
      tbl.push_back(v(1,1,4'h2,  MUL_EN ? 2 : 32, MUL_EN ? 2 : 0,0,0,0));
      tbl.push_back(v(1,1,4'hD,  MUL_EN ? 6 : 32, MUL_EN ? 3 : 0,0,0,0));
`ifdef CALC_MUL_EN
      tbl.push_back(v(0,0,4'h0,   0,0,0,0,0));
      tbl.push_back(v(1,1,4'h1,   1,0,0,0,0));
      tbl.push_back(v(1,1,4'h6,  16,0,0,0,0));
      tbl.push_back(v(1,1,4'hE,  16,1,0,0,0));
      tbl.push_back(v(1,1,4'h1,   1,2,0,0,0));
      tbl.push_back(v(1,1,4'h6,  16,2,0,0,0));
      tbl.push_back(v(1,1,4'hD,   0,3,1,0,1));
`endif

      foreach (tbl[i]) begin
         drive(tbl[i].clr_n, tbl[i].trg, tbl[i].key);
         check($sformatf("vec%0d", i), tbl[i].disp, tbl[i].st, tbl[i].ov, tbl[i].bo,
               tbl[i].zr);
      end

      // Asynchronous reset in the middle of B entry
      drive(1'b0, 1'b0, 4'h0);
      drive(1'b1, 1'b1, 4'h9);
      drive(1'b1, 1'b1, 4'hA);
      drive(1'b1, 1'b1, 4'h2);
      check("pre_reset", 8'd2, 3'd2, 1'b0, 1'b0, 1'b0);
      RESET = 1'b0;
      #2;
      check("async_reset", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      RESET = 1'b1;
      drive(1'b1, 1'b1, 4'hD);
      check("post_reset_eq", 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);

      // Randomized keys against the model
      m_reset();
      for (int n = 0; n < 3000; n++) begin
         rr = $urandom_range(0, 99);
         if (rr < 55) kk = $urandom_range(0, 9);
         else if (rr < 70) kk = 10;
         else if (rr < 80) kk = 11;
         else if (rr < 85) kk = 14;
         else if (rr < 95) kk = 13;
         else if (rr < 97) kk = 12;
         else kk = 15;
         tt = ($urandom_range(0, 3) != 0);
         cc = ($urandom_range(0, 39) != 0);
         m_step(cc, tt, kk);
         drive(cc, tt, 4'(kk));
         check($sformatf("rand%0d", n), 8'(m_disp()), 3'(mst), mov, mbo, mzr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
